// File: rtl/ast_rr_packet_mux.sv
// Avalon-ST N:1 packet mux: packet-atomic round-robin arbitration feeding a 2-entry output skid buffer.
// Optional macro AST_RR_MUX_CHANNEL_EN adds ast_source_channel_o carrying the source channel of each beat.
module ast_rr_packet_mux #(
    parameter int BYTE_W      = 8,
    parameter int AST_SYMBOLS = 1,
    parameter int AST_EMPTY_W = (AST_SYMBOLS == 1) ? 1 : $clog2(AST_SYMBOLS),
    parameter int IN_DIRS_CNT = 4,
    parameter int CH_W        = (IN_DIRS_CNT == 1) ? 1 : $clog2(IN_DIRS_CNT)
) (
    input  logic                                       clk_i,
    input  logic                                       arst_i,
    input  logic [IN_DIRS_CNT-1:0]                     chan_en_i,
    input  logic [IN_DIRS_CNT*AST_SYMBOLS*BYTE_W-1:0]  ast_sink_data_i,
    input  logic [IN_DIRS_CNT-1:0]                     ast_sink_valid_i,
    output logic [IN_DIRS_CNT-1:0]                     ast_sink_ready_o,
    input  logic [IN_DIRS_CNT*AST_EMPTY_W-1:0]         ast_sink_empty_i,
    input  logic [IN_DIRS_CNT-1:0]                     ast_sink_startofpacket_i,
    input  logic [IN_DIRS_CNT-1:0]                     ast_sink_endofpacket_i,
    output logic [AST_SYMBOLS*BYTE_W-1:0]              ast_source_data_o,
    output logic                                       ast_source_valid_o,
    input  logic                                       ast_source_ready_i,
    output logic [AST_EMPTY_W-1:0]                     ast_source_empty_o,
    output logic                                       ast_source_startofpacket_o,
`ifdef AST_RR_MUX_CHANNEL_EN
    output logic [CH_W-1:0]                            ast_source_channel_o,
`endif
    output logic                                       ast_source_endofpacket_o
);

    localparam int DATA_W = AST_SYMBOLS * BYTE_W;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state;
    logic [CH_W-1:0]         rr_ptr, grant, pick, sel;
    logic                    pick_vld;
    logic [IN_DIRS_CNT-1:0]  cand;
    logic                    can_accept;
    logic                    push, pop;

    logic [DATA_W-1:0]       in_data;
    logic [AST_EMPTY_W-1:0]  in_empty;
    logic                    in_sop, in_eop;

    logic [DATA_W-1:0]       data_q  [2];
    logic [AST_EMPTY_W-1:0]  empty_q [2];
    logic                    sop_q   [2];
    logic                    eop_q   [2];
`ifdef AST_RR_MUX_CHANNEL_EN
    logic [CH_W-1:0]         chan_q  [2];
`endif
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              count, count_nxt;

    function automatic logic [CH_W-1:0] nxt_ch(input logic [CH_W-1:0] x);
        return (int'(x) == IN_DIRS_CNT - 1) ? '0 : x + CH_W'(1);
    endfunction

    // First enabled+valid channel at or after rr_ptr, wrapping around.
    always_comb begin
        cand     = ast_sink_valid_i & chan_en_i;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < IN_DIRS_CNT; i++) begin
            if (!pick_vld && cand[(int'(rr_ptr) + i) % IN_DIRS_CNT]) begin
                pick     = CH_W'((int'(rr_ptr) + i) % IN_DIRS_CNT);
                pick_vld = 1'b1;
            end
        end
    end

    // can_accept is a flop, so sink ready never sees ast_source_ready_i combinationally.
    always_comb begin
        ast_sink_ready_o = '0;
        if (can_accept) begin
            if (state == LOCKED)
                ast_sink_ready_o[grant] = 1'b1;
            else if (pick_vld)
                ast_sink_ready_o[pick] = 1'b1;
        end
    end

    assign sel      = (state == LOCKED) ? grant : pick;
    assign push     = |(ast_sink_valid_i & ast_sink_ready_o);
    assign in_data  = ast_sink_data_i[int'(sel)*DATA_W +: DATA_W];
    assign in_empty = ast_sink_empty_i[int'(sel)*AST_EMPTY_W +: AST_EMPTY_W];
    assign in_sop   = ast_sink_startofpacket_i[sel];
    assign in_eop   = ast_sink_endofpacket_i[sel];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state  <= IDLE;
            rr_ptr <= '0;
            grant  <= '0;
        end else if (push) begin
            case (state)
                IDLE: begin
                    if (in_eop) begin
                        rr_ptr <= nxt_ch(pick);
                    end else begin
                        grant <= pick;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_eop) begin
                        state  <= IDLE;
                        rr_ptr <= nxt_ch(grant);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pop = ast_source_valid_o && ast_source_ready_i;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i]  <= '0;
                empty_q[i] <= '0;
                sop_q[i]   <= 1'b0;
                eop_q[i]   <= 1'b0;
`ifdef AST_RR_MUX_CHANNEL_EN
                chan_q[i]  <= '0;
`endif
            end
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= '0;
            can_accept <= 1'b0;
        end else begin
            if (push) begin
                data_q[wr_ptr]  <= in_data;
                empty_q[wr_ptr] <= in_empty;
                sop_q[wr_ptr]   <= in_sop;
                eop_q[wr_ptr]   <= in_eop;
`ifdef AST_RR_MUX_CHANNEL_EN
                chan_q[wr_ptr]  <= sel;
`endif
                wr_ptr <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count      <= count_nxt;
            can_accept <= (count_nxt < 2'd2);
        end
    end

    assign ast_source_valid_o         = (count != 2'd0);
    assign ast_source_data_o          = data_q[rd_ptr];
    assign ast_source_empty_o         = empty_q[rd_ptr];
    assign ast_source_startofpacket_o = sop_q[rd_ptr];
    assign ast_source_endofpacket_o   = eop_q[rd_ptr];
`ifdef AST_RR_MUX_CHANNEL_EN
    assign ast_source_channel_o       = chan_q[rd_ptr];
`endif

endmodule

// File: tb/tb_ast_rr_packet_mux.sv
// Scoreboard bench for ast_rr_packet_mux: per-channel beat queues drive the sinks, a monitor checks output order.
module tb_ast_rr_packet_mux;

    logic        clk_i = 1'b0;
    logic        arst_i = 1'b1;
    logic [3:0]  chan_en_i = 4'hF;
    logic [31:0] ast_sink_data_i = '0;
    logic [3:0]  ast_sink_valid_i = '0;
    logic [3:0]  ast_sink_ready_o;
    logic [3:0]  ast_sink_empty_i = '0;
    logic [3:0]  ast_sink_startofpacket_i = '0;
    logic [3:0]  ast_sink_endofpacket_i = '0;
    logic [7:0]  ast_source_data_o;
    logic        ast_source_valid_o;
    logic        ast_source_ready_i = 1'b1;
    logic [0:0]  ast_source_empty_o;
    logic        ast_source_startofpacket_o;
    logic        ast_source_endofpacket_o;
`ifdef AST_RR_MUX_CHANNEL_EN
    logic [1:0]  ast_source_channel_o;
`endif

    ast_rr_packet_mux dut (
        .clk_i                      (clk_i),
        .arst_i                     (arst_i),
        .chan_en_i                  (chan_en_i),
        .ast_sink_data_i            (ast_sink_data_i),
        .ast_sink_valid_i           (ast_sink_valid_i),
        .ast_sink_ready_o           (ast_sink_ready_o),
        .ast_sink_empty_i           (ast_sink_empty_i),
        .ast_sink_startofpacket_i   (ast_sink_startofpacket_i),
        .ast_sink_endofpacket_i     (ast_sink_endofpacket_i),
        .ast_source_data_o          (ast_source_data_o),
        .ast_source_valid_o         (ast_source_valid_o),
        .ast_source_ready_i         (ast_source_ready_i),
        .ast_source_empty_o         (ast_source_empty_o),
        .ast_source_startofpacket_o (ast_source_startofpacket_o),
`ifdef AST_RR_MUX_CHANNEL_EN
        .ast_source_channel_o       (ast_source_channel_o),
`endif
        .ast_source_endofpacket_o   (ast_source_endofpacket_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0] data;
        logic       empty;
        logic       sop;
        logic       eop;
        logic [1:0] ch;
    } beat_t;

    beat_t chq [4][$];
    beat_t exp_q [$];
    logic [3:0] vmask = 4'hF;
    logic       ready_toggle = 1'b0;
    int acc_cnt [4] = '{0, 0, 0, 0};
    int tests = 0, fails = 0;
    int cyc = 0, fires = 0, last_fire_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic beat_t mk(input int ch, input int pkt, input int b, input int n);
        beat_t x;
        x.data  = {2'(ch), 3'(pkt), 3'(b)};
        x.empty = 1'(b);
        x.sop   = (b == 0);
        x.eop   = (b == n - 1);
        x.ch    = 2'(ch);
        return x;
    endfunction

    task automatic load(input int ch, input int pkt, input int n);
        for (int b = 0; b < n; b++) chq[ch].push_back(mk(ch, pkt, b, n));
    endtask

    task automatic expect_pkt(input int ch, input int pkt, input int n);
        for (int b = 0; b < n; b++) exp_q.push_back(mk(ch, pkt, b, n));
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Source model: present each queue head, retire it once the handshake is seen.
    initial begin
        logic [3:0] acc;
        forever begin
            @(negedge clk_i);
            acc = ast_sink_valid_i & ast_sink_ready_o;
            @(posedge clk_i);
            #1;
            for (int c = 0; c < 4; c++) begin
                if (acc[c] && chq[c].size() > 0) begin
                    void'(chq[c].pop_front());
                    acc_cnt[c]++;
                end
            end
            if (ready_toggle) ast_source_ready_i = ~ast_source_ready_i;
            for (int c = 0; c < 4; c++) begin
                if (chq[c].size() > 0 && vmask[c]) begin
                    ast_sink_valid_i[c]         = 1'b1;
                    ast_sink_data_i[c*8 +: 8]   = chq[c][0].data;
                    ast_sink_empty_i[c]         = chq[c][0].empty;
                    ast_sink_startofpacket_i[c] = chq[c][0].sop;
                    ast_sink_endofpacket_i[c]   = chq[c][0].eop;
                end else begin
                    ast_sink_valid_i[c]         = 1'b0;
                end
            end
        end
    end

    // Monitor: every output handshake pops the scoreboard.
    always @(negedge clk_i) begin
        beat_t act, e;
        if (!arst_i && ast_source_valid_o && ast_source_ready_i) begin
            fires++;
            last_fire_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {24'd0, ast_source_data_o}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                act.data  = ast_source_data_o;
                act.empty = ast_source_empty_o;
                act.sop   = ast_source_startofpacket_o;
                act.eop   = ast_source_endofpacket_o;
`ifdef AST_RR_MUX_CHANNEL_EN
                act.ch    = ast_source_channel_o;
`else
                act.ch    = e.ch;
`endif
                chk("out_beat", 32'(act), 32'(e));
            end
        end
    end

    task automatic wait_exp(input int sz, input string name);
        int n = 0;
        while (exp_q.size() > sz && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'(sz));
    endtask

    task automatic wait_acc(input int ch, input int target, input string name);
        int n = 0;
        while (acc_cnt[ch] < target && n < 200) begin
            @(posedge clk_i);
            #2;
            n++;
        end
        chk(name, 32'(acc_cnt[ch] >= target), 32'd1);
    endtask

    task automatic wait_first_fire(input int f0, output int first_cyc);
        int n = 0;
        while (fires == f0 && n < 200) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        chk("first_fire_timeout", 32'(fires > f0), 32'd1);
        first_cyc = last_fire_cyc;
    endtask

    initial begin
        int f0, c0, base;
        #2;
        chk("rst_valid", 32'(ast_source_valid_o), 32'd0);
        chk("rst_ready", 32'(ast_sink_ready_o), 32'd0);
        chk("rst_data",  32'({ast_source_data_o, ast_source_startofpacket_o, ast_source_endofpacket_o}), 32'd0);
        repeat (2) @(posedge clk_i);
        #1 arst_i = 1'b0;

        // Idle: no sink valid -> nothing moves.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            chk("idle_out", 32'({ast_source_valid_o, ast_sink_ready_o}), 32'd0);
        end

        // Round-robin over 3-beat packets, two per channel, at full rate.
        @(posedge clk_i); #1;
        f0 = fires;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 4; c++) begin
                load(c, p, 3);
                expect_pkt(c, p, 3);
            end
        wait_first_fire(f0, c0);
        wait_exp(0, "rr_drain");
        chk("rr_span", 32'(last_fire_cyc - c0 + 1), 32'd24);

        // Single-beat packets on ch0 and ch3, rr_ptr at 0.
        @(posedge clk_i); #1;
        f0 = fires;
        load(3, 2, 1);
        load(0, 2, 1);
        expect_pkt(0, 2, 1);
        expect_pkt(3, 2, 1);
        wait_first_fire(f0, c0);
        wait_exp(0, "single_drain");
        chk("single_span", 32'(last_fire_cyc - c0 + 1), 32'd2);

        // Ch1 5-beat packet with output ready toggling.
        @(posedge clk_i); #1;
        ready_toggle = 1'b1;
        load(1, 3, 5);
        expect_pkt(1, 3, 5);
        wait_exp(0, "toggle_drain");
        ready_toggle = 1'b0;
        ast_source_ready_i = 1'b1;

        // Ch2 loses enable mid-packet; it finishes, then ch3, then ch2 waits for re-enable.
        repeat (3) @(posedge clk_i);
        #1;
        base = acc_cnt[2];
        load(2, 4, 4);
        load(2, 5, 1);
        load(3, 4, 2);
        expect_pkt(2, 4, 4);
        expect_pkt(3, 4, 2);
        expect_pkt(2, 5, 1);
        wait_acc(2, base + 2, "en_acc_timeout");
        chan_en_i[2] = 1'b0;
        wait_exp(1, "en_partial_drain");
        f0 = fires;
        repeat (10) @(negedge clk_i);
        chk("en_blocked_fires", 32'(fires), 32'(f0));
        chk("en_blocked_ready", 32'(ast_sink_ready_o), 32'd0);
        @(posedge clk_i); #1;
        chan_en_i[2] = 1'b1;
        wait_exp(0, "en_drain");

        // Ch0 stalls mid-packet while ch1 waits: lock holds.
        @(posedge clk_i); #1;
        base = acc_cnt[0];
        load(0, 6, 4);
        load(1, 6, 2);
        expect_pkt(0, 6, 4);
        expect_pkt(1, 6, 2);
        wait_acc(0, base + 2, "stall_acc_timeout");
        vmask[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("stall_ch1_ready", 32'(ast_sink_ready_o[1]), 32'd0);
        end
        @(posedge clk_i); #1;
        vmask[0] = 1'b1;
        wait_exp(0, "stall_drain");

        // Asynchronous reset mid-cycle drops valid at once.
        @(posedge clk_i); #1;
        load(1, 7, 6);
        expect_pkt(1, 7, 6);
        begin
            int n = 0;
            while (!ast_source_valid_o && n < 50) begin
                @(negedge clk_i);
                n++;
            end
        end
        chk("pre_arst_valid", 32'(ast_source_valid_o), 32'd1);
        @(posedge clk_i);
        #3 arst_i = 1'b1;
        #1;
        chk("arst_valid", 32'(ast_source_valid_o), 32'd0);
        chk("arst_ready", 32'(ast_sink_ready_o), 32'd0);
        for (int c = 0; c < 4; c++) chq[c].delete();
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1 arst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("post_arst_valid", 32'(ast_source_valid_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
